// File: rtl/shift_add_mult32.sv
// Sequential 32x32 unsigned shift-and-add multiplier driving an external 32-bit adder.
// One adder pass per cycle over 32 RUN cycles yields the 64-bit product.
module shift_add_mult32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] m, p_hi, p_lo;
    logic [5:0]  cnt;
    logic [63:0] shifted;
    logic        accept;

    // Adder inputs come from registers only, never from start or the operand ports.
    assign add_a   = p_hi;
    assign add_b   = p_lo[0] ? m : '0;
    assign add_cin = 1'b0;

    // The 65-bit {cout, sum, p_lo} shifted right by one, low bit dropped.
    assign shifted = {add_cout, add_sum, p_lo[31:1]};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == 6'd31) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            m       <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                m    <= multiplicand;
                p_lo <= multiplier;
                p_hi <= '0;
                cnt  <= '0;
            end else if (state == RUN) begin
                p_hi <= shifted[63:32];
                p_lo <= shifted[31:0];
                cnt  <= cnt + 6'd1;
                if (cnt == 6'd31) product <= shifted;
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mult32.sv
// Self-checking bench for shift_add_mult32: directed cases plus random operands
// against a plain 64-bit multiply; the external adder is modelled here.
module tb_shift_add_mult32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] multiplicand, multiplier;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        busy, done;
    logic [63:0] product;

    int n_assert = 0;
    int n_fail   = 0;
    int n_accept = 0;
    int n_done   = 0;
    int busy_cnt, cin_bad;
    bit cout_seen;

    shift_add_mult32 dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy), .done(done), .product(product)
    );

    // Team 32-bit full adder, purely combinational.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts cycles from the current negedge until done is seen (bounded).
    task automatic wait_done(output int cyc);
        cyc       = 0;
        busy_cnt  = 0;
        cin_bad   = 0;
        cout_seen = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
            if (add_cin !== 1'b0) cin_bad++;
            if (busy && add_cout) cout_seen = 1'b1;
        end while (!done && cyc < 40);
        if (done) n_done++;
    endtask

    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input string tag);
        int cyc;
        logic [63:0] exp;
        exp = {32'd0, a} * {32'd0, b};
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        n_accept++;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        cyc = 1;
        busy_cnt = busy ? 1 : 0;
        cin_bad = 0;
        cout_seen = busy && add_cout;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
            if (add_cin !== 1'b0) cin_bad++;
            if (busy && add_cout) cout_seen = 1'b1;
        end
        if (done) n_done++;
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_busycycles"}, 64'(busy_cnt), 64'd32);
        check({tag, "_product"}, product, exp);
    endtask

    initial begin
        int cyc;
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        start = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_add_a", 64'(add_a), 64'd0);
        check("rst_add_b", 64'(add_b), 64'd0);
        check("rst_add_cin", 64'(add_cin), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic and boundary cases
        do_mult(32'd3, 32'd5, "basic");
        @(negedge clk);
        check("basic_done_pulse", 64'(done), 64'd0);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
        check("max_cout_seen", 64'(cout_seen), 64'd1);
        check("max_cin_zero", 64'(cin_bad), 64'd0);
        check("max_value", product, 64'hFFFF_FFFE_0000_0001);
        do_mult(32'd0, 32'h1234_5678, "zero");
        do_mult(32'h1234_5678, 32'd1, "ident");
        check("ident_value", product, 64'h0000_0000_1234_5678);

        // Start during RUN must be ignored
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        start        = 1'b1;
        n_accept++;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        multiplicand = 32'd2;
        multiplier   = 32'd2;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("busyprot_latency", 64'(cyc + 11), 64'd33);
        check("busyprot_product", product, 64'h3F);

        // Start held: back-to-back multiplies
        @(negedge clk);
        multiplicand = 32'd6;
        multiplier   = 32'd7;
        start        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_accept++;
            wait_done(cyc);
            check("b2b_period", 64'(cyc), 64'd33);
            check("b2b_product", product, 64'd42);
        end

        // Still held in DONE: next run is accepted, then reset mid-RUN
        n_accept++;
        repeat (15) @(negedge clk);
        check("midrun_busy", 64'(busy), 64'd1);
        start = 1'b0;
        rst_n = 1'b0;
        n_accept--;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_product", product, 64'd0);
        check("midrst_add_a", 64'(add_a), 64'd0);
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) cyc++;
        end
        check("midrst_no_done", 64'(cyc), 64'd0);
        do_mult(32'd4, 32'd4, "after_rst");

        // Random operands against a 64-bit reference multiply
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = rb >> $urandom_range(31, 0);
            do_mult(ra, rb, "rand");
        end
        check("done_vs_accept", 64'(n_done), 64'(n_accept));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
